arith_sequencer: RTL
====================

Name: arith_sequencer

Overview:
Multi-cycle controller that sequences one shared add/sub and shift datapath of width N. It accepts one operation per start/done handshake and executes it. Add and sub take one execute cycle. Unsigned multiply runs as N shift-and-add iterations. Arithmetic right shift by a variable amount runs as one 1-bit shift per cycle. It sits between the lab's operand/select logic and the result display/flag logic.

Parameters:
N, 4, operand width in bits (minimum 2)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
op  input  2  00 add, 01 sub, 10 unsigned multiply, 11 arithmetic shift right of a by b
a  input  N  operand A; captured on accepted start
b  input  N  operand B / multiplier / shift amount; captured on accepted start
busy  output  1  high while in EXEC
done  output  1  one-cycle pulse; result and flags valid
result  output  2N  operation result; held until next accepted start
carry_out  output  1  add: carry; sub: no-borrow; shift: last bit shifted out; multiply: 0
zero  output  1  result == 0; updated together with done

Behaviour:
- Reset: clk and rst (sync, active-high). When rst=1 at an edge: state=IDLE; busy, done, result, carry_out and zero all go to 0; internal operand/count registers are cleared. Reset mid-operation aborts with no done pulse.
- FSM states: IDLE, EXEC, DONE.
- IDLE -> EXEC: start=1 at edge t. a, b and op are latched at that edge. busy=1 from t+1.
- EXEC -> DONE: after the op-specific cycle count. DONE -> IDLE: unconditional after one cycle. done=1 only in DONE; busy=0 in DONE.
- start outside IDLE (EXEC or DONE) is ignored. Input changes after acceptance have no effect.
- Add/sub: 1 EXEC cycle; done at t+2.
  - Computation is a + b, or a + ~b + 1, at N bits.
  - result = {N zeros, sum}.
  - carry_out = carry out of bit N-1. For sub, 1 means a >= b unsigned.
- Multiply: N EXEC cycles; done at t+N+1.
  - 2N-bit register P is initialised to {0, b}. A separate carry bit is kept.
  - Each cycle: if P[0]=1, then {c, P[2N-1:N]} = P[2N-1:N] + a. Then {c, P} is shifted right logically by 1.
  - result = P, which equals a*b unsigned. carry_out = 0.
- Shift: amount k = min(b unsigned, N).
  - EXEC lasts max(k,1) cycles. Each of the first k cycles does a 1-bit arithmetic shift right (sign bit replicated).
  - result = sign-extension of the shifted value to 2N bits.
  - carry_out = last bit shifted out, or 0 if k=0.
  - k=0: one EXEC cycle, result = sign-extended a. done at t+1+max(k,1)+... i.e. the cycle after the last EXEC cycle.
- Internal cycle counter: width clog2(N)+1. It is loaded on accept and decremented each EXEC cycle.
- zero: evaluated on the final result and registered with result.
- Outputs result, carry_out and zero change only on entry to DONE (or on reset). They hold their value through IDLE.

Test Plan:
- N=4, add a=9 b=8, start at t -> busy=1 at t+1; done=1 at t+2 only; result=0x01, carry_out=1, zero=0.
- Sub a=3 b=3 -> result=0x00, carry_out=1, zero=1. Then sub a=2 b=5 -> result=0x0D, carry_out=0, zero=0.
- Multiply a=15 b=15 -> busy high t+1..t+4; done at t+5; result=0xE1; carry_out=0. Also a=0 b=9 -> result=0x00, zero=1.
- Shift:
  - a=0111 b=2 -> done at t+3, result=0x01, carry_out=1.
  - a=1000 b=9 (saturate to 4) -> done at t+5, result=0xFF.
  - a=1000 b=0 -> done at t+2, result=0xF8, carry_out=0.
- Start a multiply, pulse start with different operands at t+2 -> ignored; result of the original op is returned. Start asserted during the DONE cycle -> ignored; IDLE is next.
- Start multiply 15*15, assert rst at t+3 -> at t+4 busy=0, result=0, no done pulse. A new add 1+1 then completes normally: result=0x02.

Source files
------------

// File: rtl/arith_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : arith_sequencer_if
// Description : Request/result bundle between the operand/select logic
//               (master) and the arith_sequencer controller (slave).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface arith_sequencer_if #(
  parameter int N = 4
);
  logic           start;
  logic [1:0]     op;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] result;
  logic           carry_out;
  logic           zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry_out, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry_out, zero
  );
endinterface

`default_nettype wire

// File: rtl/arith_sequencer.sv
//------------------------------------------------------------------------------
// Module      : arith_sequencer
// Description : Multi-cycle controller around one shared add/sub and shift
//               datapath: add, sub, shift-and-add unsigned multiply and
//               bit-serial arithmetic right shift.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arith_sequencer #(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst,
  arith_sequencer_if.slave bus
);

  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_exec = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  localparam logic [1:0] c_op_add = 2'b00;
  localparam logic [1:0] c_op_sub = 2'b01;
  localparam logic [1:0] c_op_mul = 2'b10;
  localparam logic [1:0] c_op_asr = 2'b11;

  logic [1:0]     state_q,  state_d;
  logic [1:0]     op_q,     op_d;
  logic [N-1:0]   a_q,      a_d;      // multiplicand, or the value being shifted
  logic [N-1:0]   b_q,      b_d;
  logic [2*N-1:0] p_q,      p_d;      // multiply partial product
  logic [CW-1:0]  cnt_q,    cnt_d;
  logic           shen_q,   shen_d;   // shift amount was non-zero
  logic           last_q,   last_d;   // last bit shifted out
  logic [2*N-1:0] result_q, result_d;
  logic           carry_q,  carry_d;
  logic           zero_q,   zero_d;

  logic [N:0]     w_addsub;
  logic [N:0]     w_mul_sum;
  logic [2*N-1:0] w_p_next;
  logic [N-1:0]   w_sh_next;
  logic           w_last_next;
  logic [2*N-1:0] w_final;
  logic           w_final_c;
  logic [CW-1:0]  w_k;
  logic [CW-1:0]  w_cnt_init;

  // Shared datapath: one adder pass, one multiply step, one 1-bit shift
  always_comb begin
    w_addsub    = {1'b0, a_q} + {1'b0, (op_q[0] ? ~b_q : b_q)} + (N+1)'(op_q[0]);
    w_mul_sum   = {1'b0, p_q[2*N-1:N]} + (p_q[0] ? {1'b0, a_q} : {(N+1){1'b0}});
    // {carry, high half, low half} shifted right by one
    w_p_next    = {w_mul_sum, p_q[N-1:1]};
    w_sh_next   = shen_q ? {a_q[N-1], a_q[N-1:1]} : a_q;
    w_last_next = shen_q ? a_q[0] : last_q;
    w_final     = '0;
    w_final_c   = 1'b0;
    case (op_q)
      c_op_add, c_op_sub: begin
        w_final   = {{N{1'b0}}, w_addsub[N-1:0]};
        w_final_c = w_addsub[N];
      end
      c_op_mul: begin
        w_final   = w_p_next;
        w_final_c = 1'b0;
      end
      default: begin
        w_final   = {{N{w_sh_next[N-1]}}, w_sh_next};
        w_final_c = w_last_next;
      end
    endcase
  end

  // Iteration count loaded on accept; a zero shift still takes one cycle
  always_comb begin
    w_k = (32'(bus.b) >= N) ? CW'(N) : CW'(bus.b);
    case (bus.op)
      c_op_mul: w_cnt_init = CW'(N);
      c_op_asr: w_cnt_init = (w_k == '0) ? CW'(1) : w_k;
      default:  w_cnt_init = CW'(1);
    endcase
  end

  // Next-state logic for the controller and its working registers
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    shen_d   = shen_q;
    last_d   = last_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    case (state_q)
      c_st_idle: begin
        if (bus.start) begin
          state_d = c_st_exec;
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          p_d     = {{N{1'b0}}, bus.b};
          cnt_d   = w_cnt_init;
          shen_d  = (bus.op == c_op_asr) && (bus.b != '0);
          last_d  = 1'b0;
        end
      end
      c_st_exec: begin
        if (op_q == c_op_mul) p_d = w_p_next;
        if (op_q == c_op_asr) begin
          a_d    = w_sh_next;
          last_d = w_last_next;
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = c_st_done;
          result_d = w_final;
          carry_d  = w_final_c;
          zero_d   = (w_final == '0);
        end
      end
      default: state_d = c_st_idle;
    endcase
  end

  // State register with synchronous reset; reset aborts any operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= c_st_idle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      shen_q   <= 1'b0;
      last_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      shen_q   <= shen_d;
      last_q   <= last_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy      = (state_q == c_st_exec);
  assign bus.done      = (state_q == c_st_done);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.zero      = zero_q;

endmodule

`default_nettype wire
